// File: rtl/bellek_ctrl.sv
// Single-port word memory with byte enables, registered read and a one-row-per-cycle fill sweep.
// Define BELLEK_PARITY_EN to store per-byte even parity and flag corrupted rows on read.
module bellek_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_in,
  output logic [DATA_W-1:0]   read_out,
  output logic                read_valid,
  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                busy,
  output logic                par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  // Requests (we/re/fill_start) are sampled only in IDLE; FILL ignores them.
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                rv_q, rv_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;
  logic [DATA_W-1:0]   rd_word;

`ifdef BELLEK_PARITY_EN
  logic [NB-1:0]       par [DEPTH];
  logic                pe_q, pe_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    rd_d      = rd_q;
    rv_d      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = write_in;
    mem_be    = be;
    rd_word   = mem[address];
`ifdef BELLEK_PARITY_EN
    pe_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d = ST_FILL;
          fill_d  = fill_value;
          cnt_d   = '0;
        end else begin
          mem_we = we;
          // Read sees the pre-write word, giving read-first behaviour.
          if (re) begin
            rd_d = rd_word;
            rv_d = 1'b1;
`ifdef BELLEK_PARITY_EN
            for (int i = 0; i < NB; i++) begin
              if ((^rd_word[8*i +: 8]) != par[address][i]) pe_d = 1'b1;
            end
`endif
          end
        end
      end
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = fill_q;
        mem_be    = '1;
        if (&cnt_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
      rv_q    <= 1'b0;
`ifdef BELLEK_PARITY_EN
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
`ifdef BELLEK_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

  // Storage is never cleared; reset only blocks the write on its edge so an aborted sweep stops cleanly.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
`ifdef BELLEK_PARITY_EN
          par[mem_addr][i] <= ^mem_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

  assign read_out   = rd_q;
  assign read_valid = rv_q;
  assign busy       = (state_q == ST_FILL);
`ifdef BELLEK_PARITY_EN
  assign par_err    = pe_q;
`else
  assign par_err    = 1'b0;
`endif

endmodule
